// File: rtl/systolic_array_control_unit_v2.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_array_control_unit_v2
//  Function : Step sequencer, FIFO occupancy tracking and column-adder
//             handshakes for a ROWS x COLS systolic array.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_array_control_unit_v2 #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int IN_DEPTH = 4,
   parameter int PS_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   input_en,
   input  logic                   partial_en,
   input  logic                   PE_value_ready,
   input  logic [COLS-1:0]        add_value_ready,
   input  logic [COLS-1:0]        acc_end_flags,
   output logic                   fifo_has_space,
   output logic [ROWS-1:0]        in_fifo_shift,
   output logic [COLS-1:0]        ps_fifo_shift,
   output logic [ROWS*COLS-1:0]   PE_start,
   output logic [ROWS*COLS-1:0]   PE_shift,
   output logic [COLS-1:0]        add_start,
   output logic                   drained,
   output logic                   overflow
);

   localparam int IW  = $clog2(IN_DEPTH + 1);
   localparam int PW  = $clog2(PS_DEPTH + 1);
   localparam int SW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FLW = (ROWS + COLS > 2) ? $clog2(ROWS + COLS - 1) : 1;

   localparam logic [IW-1:0]  c_IN_FULL  = IW'(IN_DEPTH);
   localparam logic [PW-1:0]  c_PS_FULL  = PW'(PS_DEPTH);
   localparam logic [SW-1:0]  c_STEP_MAX = SW'(ROWS - 1);
   localparam logic [FLW-1:0] c_FL_LOAD  = FLW'(ROWS + COLS - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_SHIFT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   step_q, step_d;
   logic [FLW-1:0]  fl_q, fl_d;
   logic [IW-1:0]   in_cnt_q [ROWS];
   logic [IW-1:0]   in_cnt_d [ROWS];
   logic [PW-1:0]   ps_cnt_q [COLS];
   logic [PW-1:0]   ps_cnt_d [COLS];
   logic [COLS-1:0] pend_q, pend_d;
   logic [COLS-1:0] abusy_q, abusy_d;
   logic            drained_q, drained_d;
   logic            overflow_q, overflow_d;

   logic            w_in_block, w_in_push, w_any_in, w_any_in_next;
   logic            w_ps_block, w_ps_push;
   logic [COLS-1:0] w_ps_nonempty;

   // Row r only joins the wavefront once the step counter has reached it.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      if (r == 0) begin : g_first
         assign in_fifo_shift[r] = (state_q == S_SHIFT) && (in_cnt_q[r] != '0);
      end else begin : g_rest
         localparam logic [SW-1:0] c_ROW = SW'(r);
         assign in_fifo_shift[r] = (state_q == S_SHIFT) && (step_q >= c_ROW) &&
                                   (in_cnt_q[r] != '0);
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_ps_nonempty[c] = (ps_cnt_q[c] != '0);
   end

   assign add_start      = pend_q & ~abusy_q & w_ps_nonempty;
   assign ps_fifo_shift  = add_value_ready & abusy_q;
   assign drained        = drained_q;
   assign overflow       = overflow_q;

   // A write is all-or-nothing: one full, non-popping FIFO blocks every row.
   always_comb begin
      fifo_has_space = 1'b1;
      w_in_block     = 1'b0;
      w_any_in       = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         if (in_cnt_q[r] == c_IN_FULL) begin
            fifo_has_space = 1'b0;
            if (!in_fifo_shift[r]) w_in_block = 1'b1;
         end
         if (in_cnt_q[r] != '0) w_any_in = 1'b1;
      end
   end

   always_comb begin
      w_ps_block = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if ((ps_cnt_q[c] == c_PS_FULL) && !ps_fifo_shift[c]) w_ps_block = 1'b1;
      end
   end

   assign w_in_push = input_en && !w_in_block;
   assign w_ps_push = partial_en && !w_ps_block;

   always_comb begin
      w_any_in_next = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         in_cnt_d[r] = in_cnt_q[r];
         if (w_in_push && !in_fifo_shift[r]) begin
            in_cnt_d[r] = in_cnt_q[r] + IW'(1);
         end else if (!w_in_push && in_fifo_shift[r]) begin
            in_cnt_d[r] = in_cnt_q[r] - IW'(1);
         end
         if (in_cnt_d[r] != '0) w_any_in_next = 1'b1;
      end
   end

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         ps_cnt_d[c] = ps_cnt_q[c];
         if (w_ps_push && !ps_fifo_shift[c]) begin
            ps_cnt_d[c] = ps_cnt_q[c] + PW'(1);
         end else if (!w_ps_push && ps_fifo_shift[c]) begin
            ps_cnt_d[c] = ps_cnt_q[c] - PW'(1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      fl_d     = fl_q;
      PE_start = '0;
      PE_shift = '0;
      case (state_q)
         S_IDLE: begin
            if (w_any_in || (fl_q != '0)) state_d = S_START;
         end
         S_START: begin
            PE_start = '1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (PE_value_ready) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            PE_shift = '1;
            if (|in_fifo_shift) begin
               fl_d = c_FL_LOAD;
            end else if (fl_q != '0) begin
               fl_d = fl_q - FLW'(1);
            end
            step_d = (step_q == c_STEP_MAX) ? step_q : step_q + SW'(1);
            // The flush tail keeps stepping until the last row has drained through.
            if (w_any_in_next || (fl_d != '0)) begin
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
               step_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pend_d     = (pend_q & ~add_start) |
                   ((state_q == S_SHIFT) ? acc_end_flags : '0);
      abusy_d    = (abusy_q & ~ps_fifo_shift) | add_start;
      overflow_d = overflow_q | (input_en && w_in_block) | (partial_en && w_ps_block);
      drained_d  = (state_q == S_IDLE) && (fl_q == '0) && !w_any_in &&
                   (pend_q == '0) && (abusy_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         fl_q       <= '0;
         pend_q     <= '0;
         abusy_q    <= '0;
         drained_q  <= 1'b1;
         overflow_q <= 1'b0;
         for (int r = 0; r < ROWS; r++) in_cnt_q[r] <= '0;
         for (int c = 0; c < COLS; c++) ps_cnt_q[c] <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         fl_q       <= fl_d;
         pend_q     <= pend_d;
         abusy_q    <= abusy_d;
         drained_q  <= drained_d;
         overflow_q <= overflow_d;
         for (int r = 0; r < ROWS; r++) in_cnt_q[r] <= in_cnt_d[r];
         for (int c = 0; c < COLS; c++) ps_cnt_q[c] <= ps_cnt_d[c];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_control_unit_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_array_control_unit_v2
//  Function : Scoreboard bench for 4x4 and 2x8 configurations of the
//             systolic array control unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_array_control_unit_v2;

   localparam int IN_D = 4;
   localparam int PS_D = 4;

   typedef struct packed {
      logic        space;
      logic [7:0]  insh;
      logic [7:0]  pssh;
      logic [31:0] pst;
      logic [31:0] psh;
      logic [7:0]  ast;
      logic        drn;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit done [2];

   task automatic chk(input string nm, input int got, input int req);
      nvec++;
      if (got != req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, req);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int R = (g == 0) ? 4 : 2;
      localparam int C = (g == 0) ? 4 : 8;

      logic             rst, input_en, partial_en, PE_value_ready;
      logic [C-1:0]     add_value_ready, acc_end_flags;
      logic             fifo_has_space, drained, overflow;
      logic [R-1:0]     in_fifo_shift;
      logic [C-1:0]     ps_fifo_shift, add_start;
      logic [R*C-1:0]   PE_start, PE_shift;

      systolic_array_control_unit_v2 #(
         .ROWS(R), .COLS(C), .IN_DEPTH(IN_D), .PS_DEPTH(PS_D)
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .input_en       (input_en),
         .partial_en     (partial_en),
         .PE_value_ready (PE_value_ready),
         .add_value_ready(add_value_ready),
         .acc_end_flags  (acc_end_flags),
         .fifo_has_space (fifo_has_space),
         .in_fifo_shift  (in_fifo_shift),
         .ps_fifo_shift  (ps_fifo_shift),
         .PE_start       (PE_start),
         .PE_shift       (PE_shift),
         .add_start      (add_start),
         .drained        (drained),
         .overflow       (overflow)
      );

      exp_t q [$];
      int   n_start = 0;
      int   n_pop0  = 0;

      // Reference model: 0=idle 1=start 2=wait 3=shift
      int cin [8];
      int cps [8];
      bit pend [8];
      bit busy [8];
      int st, step, fl;
      bit ovf, drn;

      task automatic model_reset();
         for (int i = 0; i < 8; i++) begin
            cin[i] = 0; cps[i] = 0; pend[i] = 0; busy[i] = 0;
         end
         st = 0; step = 0; fl = 0; ovf = 0; drn = 1;
      endtask

      task automatic model_out(input logic [7:0] avr, output exp_t e);
         e = '0;
         e.space = 1'b1;
         for (int r = 0; r < R; r++) begin
            if (cin[r] >= IN_D) e.space = 1'b0;
            e.insh[r] = (st == 3) && (step >= r) && (cin[r] > 0);
         end
         for (int i = 0; i < R * C; i++) begin
            e.pst[i] = (st == 1);
            e.psh[i] = (st == 3);
         end
         for (int c = 0; c < C; c++) begin
            e.ast[c]  = pend[c] && !busy[c] && (cps[c] > 0);
            e.pssh[c] = avr[c] && busy[c];
         end
         e.drn = drn;
         e.ovf = ovf;
      endtask

      task automatic model_cyc(input bit ie, input bit pe, input bit rdy,
                               input logic [7:0] avr, input logic [7:0] aef,
                               output exp_t e);
         bit any_old, any_new, nd, blk, all_idle;
         model_out(avr, e);
         any_old = 0;
         for (int r = 0; r < R; r++) if (cin[r] > 0) any_old = 1;
         all_idle = 1;
         for (int c = 0; c < C; c++) if (pend[c] || busy[c]) all_idle = 0;
         nd = (st == 0) && (fl == 0) && !any_old && all_idle;
         blk = 0;
         for (int r = 0; r < R; r++) if (cin[r] == IN_D && !e.insh[r]) blk = 1;
         if (ie && blk) ovf = 1;
         for (int r = 0; r < R; r++)
            cin[r] = cin[r] + ((ie && !blk) ? 1 : 0) - (e.insh[r] ? 1 : 0);
         blk = 0;
         for (int c = 0; c < C; c++) if (cps[c] == PS_D && !e.pssh[c]) blk = 1;
         if (pe && blk) ovf = 1;
         for (int c = 0; c < C; c++) begin
            cps[c]  = cps[c] + ((pe && !blk) ? 1 : 0) - (e.pssh[c] ? 1 : 0);
            busy[c] = (busy[c] && !e.pssh[c]) || e.ast[c];
            pend[c] = (pend[c] && !e.ast[c]) || ((st == 3) && aef[c]);
         end
         case (st)
            0: if (any_old || fl > 0) st = 1;
            1: st = 2;
            2: if (rdy) st = 3;
            default: begin
               fl   = (|e.insh) ? (R + C - 2) : ((fl > 0) ? fl - 1 : 0);
               step = (step + 1 > R - 1) ? R - 1 : step + 1;
               any_new = 0;
               for (int r = 0; r < R; r++) if (cin[r] > 0) any_new = 1;
               if (any_new || fl > 0) st = 1;
               else begin
                  st = 0;
                  step = 0;
               end
            end
         endcase
         drn = nd;
      endtask

      // Drives one cycle, pushes its expectation, returns 4 time units after the falling edge.
      task automatic cyc(input bit r_, input bit ie, input bit pe, input bit rdy,
                         input logic [7:0] avr, input logic [7:0] aef);
         exp_t e;
         @(negedge clk);
         #1;
         rst             = r_;
         input_en        = ie;
         partial_en      = pe;
         PE_value_ready  = rdy;
         add_value_ready = avr[C-1:0];
         acc_end_flags   = aef[C-1:0];
         if (r_) begin
            model_reset();
            model_out(avr, e);
         end else begin
            model_cyc(ie, pe, rdy, avr, aef, e);
         end
         q.push_back(e);
         #3;
      endtask

      initial begin : monitor
         exp_t e, got;
         forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
               e         = q.pop_front();
               got       = '0;
               got.space = fifo_has_space;
               got.insh  = 8'(in_fifo_shift);
               got.pssh  = 8'(ps_fifo_shift);
               got.pst   = 32'(PE_start);
               got.psh   = 32'(PE_shift);
               got.ast   = 8'(add_start);
               got.drn   = drained;
               got.ovf   = overflow;
               if (PE_start[0]) n_start++;
               if (in_fifo_shift[0]) n_pop0++;
               nvec++;
               if (got !== e) begin
                  nerr++;
                  $display("FAIL cfg%0d outputs: got %h, expected %h", g, got, e);
               end
            end
         end
      end

      initial begin : driver
         rst = 1'b1; input_en = 1'b0; partial_en = 1'b0; PE_value_ready = 1'b0;
         add_value_ready = '0; acc_end_flags = '0;
         model_reset();
         cyc(1, 0, 0, 0, 0, 0);
         cyc(1, 0, 0, 0, 0, 0);
         chk("reset_drained", int'(drained), 1);
         chk("reset_space", int'(fifo_has_space), 1);

         // Single batch with PE_value_ready held high
         cyc(0, 1, 0, 1, 0, 0);
         n_start = 0;
         repeat (50) cyc(0, 0, 0, 1, 0, 0);
         chk("start_pulses", n_start, R + (R + C - 2));
         chk("drained_after_batch", int'(drained), 1);

         // Reset while stuck in WAIT, then fill and overflow
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 1, 0, 0, 0, 0);
         repeat (3) cyc(0, 0, 0, 0, 0, 0);
         cyc(1, 0, 0, 0, 0, 0);
         chk("midwait_rst_start", int'(PE_start != '0), 0);
         chk("midwait_rst_drained", int'(drained), 1);
         chk("midwait_rst_space", int'(fifo_has_space), 1);
         cyc(0, 0, 0, 0, 0, 0);
         repeat (IN_D) cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
         chk("space_when_full", int'(fifo_has_space), 0);
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
         chk("overflow_set", int'(overflow), 1);
         n_pop0 = 0;
         repeat (80) cyc(0, 0, 0, 1, 0, 0);
         chk("row0_pops_after_fill", n_pop0, IN_D);

         // Push and pop on row 0 in the same cycle
         cyc(1, 0, 0, 0, 0, 0);
         cyc(0, 1, 0, 1, 0, 0);
         for (int k = 0; k < 20 && st != 3; k++) cyc(0, 0, 0, 1, 0, 0);
         cyc(0, 1, 0, 1, 0, 0);
         repeat (60) cyc(0, 0, 0, 1, 0, 0);

         // Column 2 adder handshake
         cyc(1, 0, 0, 0, 0, 0);
         cyc(0, 1, 0, 1, 0, 0);
         for (int k = 0; k < 20 && st != 3; k++) cyc(0, 0, 0, 1, 0, 0);
         cyc(0, 0, 0, 0, 0, 8'h04);
         cyc(0, 0, 0, 0, 0, 0);
         chk("no_add_start_empty_ps", int'(add_start[2]), 0);
         cyc(0, 0, 1, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
         chk("add_start_col2", int'(add_start[2]), 1);
         cyc(0, 0, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 8'h04, 0);
         chk("ps_shift_col2", int'(ps_fifo_shift[2]), 1);
         repeat (5) cyc(0, 0, 0, 1, 0, 0);

         // Random traffic
         for (int k = 0; k < 1500; k++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1,
                8'($urandom),
                8'($urandom & $urandom));
         end
         cyc(0, 0, 0, 0, 0, 0);
         done[g] = 1'b1;
      end
   end

   initial begin : finisher
      for (int k = 0; k < 20000; k++) begin
         @(posedge clk);
         if (done[0] && done[1]) break;
      end
      if (!(done[0] && done[1])) begin
         nvec++;
         nerr++;
         $display("FAIL timeout: got unfinished stimulus, expected completion");
      end
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_array_control_unit_v2.md
Name: systolic_array_control_unit_v2

Overview:
- Parametrised successor control unit for the ROWS x COLS systolic array.
- Generalises the square N x N array to rectangular shapes.
- Tracks per-row input FIFO occupancy and partial-sum FIFO occupancy.
- Sequences PE start/shift steps with a skewed wavefront ramp-up and a flush tail.
- Runs per-column partial-sum adder handshakes and reports overflow and drain status.
- Sits between the memory-side input/partial buses and the PE grid, input FIFOs and column adders.

Parameters:
- ROWS, 4, number of PE rows (= input FIFOs).
- COLS, 4, number of PE columns (= partial-sum FIFOs and adders).
- IN_DEPTH, 4, entries per input FIFO.
- PS_DEPTH, 4, entries per partial-sum FIFO.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- input_en  in  1  input row vector written to all ROWS input FIFOs this cycle.
- partial_en  in  1  partial-sum vector written to all COLS ps FIFOs this cycle.
- PE_value_ready  in  1  all PEs finished the current MAC step.
- add_value_ready  in  COLS  adder c finished.
- acc_end_flags  in  COLS  bottom-row PE c output is the final accumulation.
- fifo_has_space  out  1  every input FIFO has a free entry.
- in_fifo_shift  out  ROWS  pop input FIFO r.
- ps_fifo_shift  out  COLS  pop ps FIFO c.
- PE_start  out  ROWS*COLS  start MAC, index r*COLS+c.
- PE_shift  out  ROWS*COLS  shift PE operands.
- add_start  out  COLS  start adder c.
- drained  out  1  array, FIFOs and adders idle and empty.
- overflow  out  1  sticky: write attempted to a full FIFO.

Behaviour:
- Reset (async, any state): FSM=IDLE; all counters cleared; drained=1; fifo_has_space=1; all other outputs 0. An operation in progress at reset is abandoned with no partial pulses.
- Input counters in_cnt[r], 0..IN_DEPTH:
  - input_en increments all rows; a pop on row r decrements row r.
  - Push and pop on the same row in the same cycle leaves the count unchanged.
  - fifo_has_space = AND over r of (in_cnt[r] < IN_DEPTH), combinational.
  - input_en while any row is full (and that row is not popping): the write is ignored for every row and overflow is set until reset.
- Partial-sum counters ps_cnt[c], 0..PS_DEPTH: same rules, driven by partial_en and ps_fifo_shift[c]; overflow is shared.
- Step FSM:
  - IDLE -> START when any in_cnt > 0 or flush counter fl > 0.
  - START (1 cycle): PE_start all ones. -> WAIT.
  - WAIT: hold until PE_value_ready=1. -> SHIFT on the next edge. PE_value_ready outside WAIT is ignored.
  - SHIFT (1 cycle): PE_shift all ones; in_fifo_shift[r]=1 iff step >= r and in_cnt[r] > 0. Then step = min(step+1, ROWS-1). -> START if work remains, else IDLE.
- Work remains iff any in_cnt > 0 or fl > 0, evaluated after the SHIFT updates.
- Flush counter fl, loaded to ROWS+COLS-2 in any SHIFT that pops. Otherwise it decrements in SHIFT (saturating at 0).
- When FSM enters IDLE with fl=0, step resets to 0, so the next batch ramps again.
- Minimum step length is 3 cycles (START, WAIT with immediate ready, SHIFT).
- Adders, per column c:
  - In SHIFT, acc_end_flags[c]=1 sets pend[c].
  - add_start[c] pulses 1 cycle when pend[c] && !abusy[c] && ps_cnt[c] > 0. It then clears pend[c] and sets abusy[c].
  - add_value_ready[c] while abusy[c]: ps_fifo_shift[c]=1 in the same cycle (combinational) and abusy[c] clears. add_value_ready[c] without abusy[c] is ignored.
  - pend[c] set while already set stays 1; a second end flag before service is merged.
- drained = FSM IDLE && fl=0 && all in_cnt=0 && no pend && no abusy. It is registered, updating on the cycle after the condition changes.

Test Plan:
- Reset mid-WAIT with in_cnt={2,2,2,2}: all outputs 0 except drained=1 and fifo_has_space=1; the next input_en makes in_cnt=1 on every row.
- ROWS=COLS=4: 1 input_en, PE_value_ready tied to 1. Steps 0..3 pop rows 0..3 in turn, one per step. Then 6 flush steps; drained=1 one cycle after the final SHIFT. Total 10 START pulses.
- 4 back-to-back input_en at IN_DEPTH=4 with no steps: fifo_has_space=0 after the 4th; a 5th input_en sets overflow=1 and counts stay at 4.
- Push and pop on row 0 in the same cycle with in_cnt[0]=1: count stays 1.
- acc_end_flags[2]=1 in SHIFT with ps_cnt[2]=0: no add_start. partial_en -> add_start[2] the next cycle. add_value_ready[2] 3 cycles later -> ps_fifo_shift[2] in the same cycle, ps_cnt[2]=0.
- ROWS=2, COLS=8: flush length is 8 steps; PE_start width is 16 and all bits pulse together.
